mem_clear_ctrl: RTL
===================

MEM_CLEAR_CTRL -- requirements
Module: mem_clear_ctrl

Interface
REQ-001 SHALL have parameter SDR_AW, default 25, SDRAM word-address width.
REQ-002 SHALL have parameter SDR_WORDS, default 2**25, number of SDRAM words cleared per run.
REQ-003 SHALL have parameter SDR_PACE, default 32, clk_sys cycles per SDRAM write, valid range 2..256.
REQ-004 SHALL have parameter DDR_AW, default 29, DDRAM 64-bit-word address width.
REQ-005 SHALL have parameter DDR_BURST, default 128, beats per DDRAM burst, valid range 1..255.
REQ-006 SHALL have parameter DDR_WORDS, default 2**24, DDRAM words cleared per run, an integer multiple of DDR_BURST.
REQ-007 SHALL have ports (name  direction  width  meaning): clk_sys  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: start  in  1  one-cycle run request; hold  in  1  suspend issuing new writes.
REQ-009 SHALL have ports: sdr_addr  out  SDR_AW  SDRAM write address; sdr_we  out  1  one-cycle SDRAM write strobe.
REQ-010 SHALL have ports: ddr_addr  out  DDR_AW; ddr_burstcnt  out  8; ddr_we  out  1; ddr_din  out  64; ddr_be  out  8; ddr_busy  in  1  Avalon-MM waitrequest.
REQ-011 SHALL have ports: busy  out  1  any channel running; done  out  1  all enabled channels finished.

Function
REQ-012 SHALL run one FSM per channel with states IDLE, RUN, DONE; start in IDLE or DONE moves the channel to RUN with address 0 and clears done.
REQ-013 SHALL ignore start while any channel is in RUN.
REQ-014 SDRAM: pace counter counts 0..SDR_PACE-1 in RUN; sdr_we is high for exactly the cycle the counter equals SDR_PACE-1.
REQ-015 SDRAM: sdr_addr SHALL be stable during sdr_we and increment by 1 on the following cycle.
REQ-016 SDRAM: after the write at address SDR_WORDS-1, the channel enters DONE; sdr_addr SHALL wrap to 0 and never exceed SDR_WORDS-1.
REQ-017 DDRAM: a burst begins with ddr_we=1, ddr_burstcnt=DDR_BURST, ddr_addr=burst base; a beat is accepted on each cycle with ddr_we & ~ddr_busy.
REQ-018 DDRAM: ddr_we, ddr_addr and ddr_burstcnt SHALL hold while ddr_busy=1.
REQ-019 DDRAM: ddr_we stays high until DDR_BURST beats are accepted; the next burst base is the previous base + DDR_BURST, with no idle cycle required between bursts.
REQ-020 DDRAM: the channel enters DONE after DDR_WORDS/DDR_BURST bursts.
REQ-021 ddr_din SHALL be all zero; ddr_be SHALL be 8'hFF whenever ddr_we=1.
REQ-022 While hold=1, the SDRAM pace counter SHALL freeze and no new DDRAM burst SHALL start; a DDRAM burst already in progress SHALL complete.
REQ-023 busy = any channel in RUN; done = all enabled channels in DONE, registered, rising the cycle after the last channel enters DONE.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force all FSMs to IDLE and all outputs, counters and addresses to 0, including mid-burst.
REQ-025 After rst_n deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-026 With MEM_CLEAR_DDRAM_EN defined, the DDRAM channel SHALL be present as specified.
REQ-027 Without MEM_CLEAR_DDRAM_EN, the DDRAM channel logic SHALL be absent: ddr_we=0, ddr_addr=0, ddr_burstcnt=0, ddr_be=0, ddr_busy ignored, and done SHALL depend on the SDRAM channel only.

Structure
REQ-028 A shared package mem_clear_pkg SHALL hold the channel state enum (IDLE, RUN, DONE) and the constant DDR_BE_ALL=8'hFF.
REQ-029 The DDRAM burst engine SHALL be a sub-module named mem_clear_burst, instantiated under MEM_CLEAR_DDRAM_EN.

Verification
REQ-030 SDR_PACE=4, SDR_WORDS=3, start pulse -> sdr_we at cycles 4, 8, 12 after start with addresses 0, 1, 2; done rises 1 cycle after the third write; busy falls at the same time.
REQ-031 DDR_BURST=4, DDR_WORDS=8, ddr_busy=0 -> 8 consecutive ddr_we cycles; ddr_addr=0 for beats 0-3 and 4 for beats 4-7; ddr_burstcnt=4.
REQ-032 ddr_busy high for 3 cycles at beat 2 -> ddr_we, ddr_addr and ddr_burstcnt are held; the burst still completes with exactly 4 accepted beats.
REQ-033 hold=1 asserted at beat 1 of a DDRAM burst -> beats 2-3 still complete; no new burst and no sdr_we occur until hold=0; the SDRAM pace counter resumes from its frozen value.
REQ-034 rst_n low mid-burst -> all outputs are 0 the same cycle; a second start during RUN is ignored; start in DONE restarts at address 0.

Source files
------------

// File: rtl/mem_clear_ctrl_pkg.sv
// Shared definitions for the memory-clear controller: the per-channel
// state encoding and the DDRAM byte-enable constant.
package mem_clear_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_t;

  localparam logic [7:0] DDR_BE_ALL = 8'hFF;

endpackage

// File: rtl/mem_clear_ctrl_if.sv
// Memory-side bus of the clear controller: the SDRAM write strobe/address
// and the Avalon-MM style DDRAM burst-write signals.
interface mem_clear_ctrl_if #(
  parameter int SDR_AW = 25,
  parameter int DDR_AW = 29
);

  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_we;
  logic [DDR_AW-1:0] ddr_addr;
  logic [7:0]        ddr_burstcnt;
  logic              ddr_we;
  logic [63:0]       ddr_din;
  logic [7:0]        ddr_be;
  logic              ddr_busy;

  modport master (
    output sdr_addr, sdr_we,
    output ddr_addr, ddr_burstcnt, ddr_we, ddr_din, ddr_be,
    input  ddr_busy
  );

  modport slave (
    input  sdr_addr, sdr_we,
    input  ddr_addr, ddr_burstcnt, ddr_we, ddr_din, ddr_be,
    output ddr_busy
  );

endinterface

// File: rtl/mem_clear_burst.sv
// DDRAM clear engine: writes DDR_WORDS zero words as back-to-back bursts of
// DDR_BURST beats. The command (we/addr/burstcnt) holds while ddr_busy is
// high. hold only blocks the start of a new burst; a burst in flight finishes.
module mem_clear_burst
  import mem_clear_pkg::*;
#(
  parameter int DDR_AW    = 29,
  parameter int DDR_BURST = 128,
  parameter int DDR_WORDS = 2**24
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              go,
  input  logic              hold,
  input  logic              ddr_busy,
  output logic [DDR_AW-1:0] ddr_addr,
  output logic [7:0]        ddr_burstcnt,
  output logic              ddr_we,
  output logic [7:0]        ddr_be,
  output logic              run,
  output logic              done_nx
);

  localparam logic [DDR_AW-1:0] LAST_BASE = DDR_AW'(DDR_WORDS - DDR_BURST);
  localparam logic [DDR_AW-1:0] BURST_INC = DDR_AW'(DDR_BURST);
  localparam logic [7:0]        BEAT_LAST = 8'(DDR_BURST - 1);

  chan_state_t       state, state_nx;
  logic [DDR_AW-1:0] base, base_nx;
  logic [7:0]        beat, beat_nx;
  logic              we_q, we_nx;
  logic              accept;

  // State and burst bookkeeping registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
      beat  <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nx;
      base  <= base_nx;
      beat  <= beat_nx;
      we_q  <= we_nx;
    end
  end

  // Next-state: count accepted beats, chain bursts unless held, stop after the last.
  always_comb begin
    state_nx = state;
    base_nx  = base;
    beat_nx  = beat;
    we_nx    = we_q;
    accept   = we_q & ~ddr_busy;
    case (state)
      IDLE, DONE: begin
        if (go) begin
          state_nx = RUN;
          base_nx  = '0;
          beat_nx  = '0;
          we_nx    = ~hold;
        end
      end
      RUN: begin
        if (accept) begin
          if (beat == BEAT_LAST) begin
            beat_nx = '0;
            if (base == LAST_BASE) begin
              state_nx = DONE;
              base_nx  = '0;
              we_nx    = 1'b0;
            end else begin
              base_nx = base + BURST_INC;
              we_nx   = ~hold;
            end
          end else begin
            beat_nx = beat + 1'b1;
          end
        end else if (!we_q && !hold) begin
          we_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ddr_we       = we_q;
  assign ddr_addr     = base;
  assign ddr_burstcnt = we_q ? 8'(DDR_BURST) : 8'h00;
  assign ddr_be       = we_q ? DDR_BE_ALL : 8'h00;
  assign run          = (state == RUN);
  assign done_nx      = (state_nx == DONE);

endmodule

// File: rtl/mem_clear_ctrl.sv
// Memory-clear controller: zeroes SDRAM one word every SDR_PACE cycles and,
// when built with MEM_CLEAR_DDRAM_EN defined, zeroes DDRAM in bursts through
// mem_clear_burst. A start pulse launches all channels together; done rises
// once every enabled channel has finished.
module mem_clear_ctrl
  import mem_clear_pkg::*;
#(
  parameter int SDR_AW    = 25,
  parameter int SDR_WORDS = 2**25,
  parameter int SDR_PACE  = 32,
  parameter int DDR_AW    = 29,
  parameter int DDR_BURST = 128,
  parameter int DDR_WORDS = 2**24
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  mem_clear_ctrl_if.master mem,
  output logic             busy,
  output logic             done
);

  localparam int                PACE_W    = $clog2(SDR_PACE);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(SDR_PACE - 1);
  localparam logic [SDR_AW-1:0] SDR_LAST  = SDR_AW'(SDR_WORDS - 1);

  chan_state_t       sdr_st, sdr_st_nx;
  logic [PACE_W-1:0] pace, pace_nx;
  logic [SDR_AW-1:0] sdr_addr, sdr_addr_nx;
  logic              sdr_we;
  logic              sdr_run;
  logic              ddr_run;
  logic              ddr_done_nx;
  logic              go;
  logic              done_nx;

  assign sdr_run = (sdr_st == RUN);
  // A run request is honoured only when no channel is mid-run.
  assign go      = start & ~(sdr_run | ddr_run);

  // SDRAM channel state, pace counter and address registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sdr_st   <= IDLE;
      pace     <= '0;
      sdr_addr <= '0;
    end else begin
      sdr_st   <= sdr_st_nx;
      pace     <= pace_nx;
      sdr_addr <= sdr_addr_nx;
    end
  end

  // SDRAM next-state: write on the last pace count, freeze everything under hold.
  always_comb begin
    sdr_st_nx   = sdr_st;
    pace_nx     = pace;
    sdr_addr_nx = sdr_addr;
    sdr_we      = 1'b0;
    case (sdr_st)
      IDLE, DONE: begin
        if (go) begin
          sdr_st_nx   = RUN;
          pace_nx     = '0;
          sdr_addr_nx = '0;
        end
      end
      RUN: begin
        if (!hold) begin
          if (pace == PACE_LAST) begin
            sdr_we  = 1'b1;
            pace_nx = '0;
            if (sdr_addr == SDR_LAST) begin
              sdr_st_nx   = DONE;
              sdr_addr_nx = '0;
            end else begin
              sdr_addr_nx = sdr_addr + 1'b1;
            end
          end else begin
            pace_nx = pace + 1'b1;
          end
        end
      end
      default: sdr_st_nx = IDLE;
    endcase
  end

  assign mem.sdr_we   = sdr_we;
  assign mem.sdr_addr = sdr_addr;
  assign mem.ddr_din  = '0;

`ifdef MEM_CLEAR_DDRAM_EN
  mem_clear_burst #(
    .DDR_AW    (DDR_AW),
    .DDR_BURST (DDR_BURST),
    .DDR_WORDS (DDR_WORDS)
  ) u_burst (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .go           (go),
    .hold         (hold),
    .ddr_busy     (mem.ddr_busy),
    .ddr_addr     (mem.ddr_addr),
    .ddr_burstcnt (mem.ddr_burstcnt),
    .ddr_we       (mem.ddr_we),
    .ddr_be       (mem.ddr_be),
    .run          (ddr_run),
    .done_nx      (ddr_done_nx)
  );
`else
  // No DDRAM channel: drive its bus idle and let done follow SDRAM alone.
  localparam int ddr_cfg_unused = DDR_AW + DDR_BURST + DDR_WORDS;
  logic ddr_busy_unused;
  assign ddr_busy_unused  = mem.ddr_busy;
  assign mem.ddr_addr     = '0;
  assign mem.ddr_burstcnt = '0;
  assign mem.ddr_we       = 1'b0;
  assign mem.ddr_be       = '0;
  assign ddr_run          = 1'b0;
  assign ddr_done_nx      = 1'b1;
`endif

  assign busy    = sdr_run | ddr_run;
  assign done_nx = (sdr_st_nx == DONE) & ddr_done_nx;

  // done is registered from the next state so it rises as busy falls.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= done_nx;
    end
  end

endmodule
